// File: rtl/fwd_axis_reader.sv
// fwd_axis_reader: forwarder-side reader for the P3 packet buffer.
// Claims a ready buffer (rdy/ack), reads NW words through a credit-limited
// read pipeline into a skid FIFO, streams them as AXI-Stream with TKEEP/TLAST,
// then reports completion with the done/done_ack handshake.
// Optional: define FWD_AXIS_STATS_EN to add fwd_pkt_cnt / fwd_byte_cnt outputs.
`timescale 1ns/1ps
module fwd_axis_reader #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned PLEN_WIDTH = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy_for_fwd,
    output logic                      rdy_for_fwd_ack,
    output logic [ADDR_WIDTH-1:0]     fwd_addr,
    output logic                      fwd_rd_en,
    input  logic [DATA_WIDTH-1:0]     fwd_rd_data,
    input  logic                      fwd_rd_data_vld,
    input  logic [PLEN_WIDTH-1:0]     fwd_byte_len,
    output logic                      fwd_done,
    input  logic                      fwd_done_ack,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready
`ifdef FWD_AXIS_STATS_EN
    ,
    output logic [31:0]               fwd_pkt_cnt,
    output logic [63:0]               fwd_byte_cnt
`endif
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned NWW   = ADDR_WIDTH + 1;
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned RW    = $clog2(BYTES) + 1;
    localparam int unsigned MAXW  = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_CLAIM, S_LEN, S_READ, S_DRAIN, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [PLEN_WIDTH-1:0]   len_q, len_d;
    logic [NWW-1:0]          nw_q, nw_d;
    logic [NWW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [NWW-1:0]          beat_q, beat_d;
    logic [RD_LAT-1:0]       lat_sr_q, lat_sr_d;
    logic [CW-1:0]           infl_q, infl_d;

    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_q, rdp_q;
    logic [CW-1:0]           cnt_q;

    logic [PLEN_WIDTH:0]     words_w;
    logic [NWW-1:0]          nw_calc;
    logic [PLEN_WIDTH-1:0]   len_calc;
    logic [RW-1:0]           rem;
    logic [BYTES-1:0]        ones;
    logic [CW:0]             occ;
    logic                    push, pop, is_last, can_read, rd_en;

    // Word count and clamped length from the requested byte length.
    always_comb begin
        words_w = ({1'b0, fwd_byte_len} + (PLEN_WIDTH+1)'(BYTES - 1)) / (PLEN_WIDTH+1)'(BYTES);
        if (words_w > (PLEN_WIDTH+1)'(MAXW)) begin
            nw_calc  = NWW'(MAXW);
            len_calc = PLEN_WIDTH'(MAXW * BYTES);
        end else begin
            nw_calc  = NWW'(words_w);
            len_calc = fwd_byte_len;
        end
    end

    // Stream output side: FIFO head, beat position and keep mask.
    always_comb begin
        ones          = '1;
        rem           = RW'(len_q % PLEN_WIDTH'(BYTES));
        is_last       = (beat_q == nw_q - NWW'(1));
        m_axis_tvalid = (cnt_q != '0);
        pop           = m_axis_tvalid && m_axis_tready;
        push          = fwd_rd_data_vld && (state_q == S_READ || state_q == S_DRAIN);
        m_axis_tdata  = m_axis_tvalid ? mem_q[rdp_q] : '0;
        m_axis_tlast  = m_axis_tvalid && is_last;
        m_axis_tkeep  = '0;
        if (m_axis_tvalid)
            m_axis_tkeep = (is_last && rem != '0) ? ~(ones >> rem) : ones;
    end

    // Credit check counts the beat leaving this cycle so a FIFO of RD_LAT+1
    // entries can sustain one word per cycle.
    always_comb begin
        occ      = (CW+1)'(cnt_q) + (CW+1)'(infl_q) - (CW+1)'(pop);
        can_read = occ < (CW+1)'(FIFO_DEPTH);
        rd_en    = (state_q == S_READ) && (rd_ptr_q < nw_q) && can_read;
    end

    // FSM next-state, handshake outputs and read pointer/beat counter updates.
    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        nw_d            = nw_q;
        rd_ptr_d        = rd_ptr_q;
        beat_d          = beat_q;
        rdy_for_fwd_ack = 1'b0;
        fwd_done        = 1'b0;
        fwd_rd_en       = rd_en;
        fwd_addr        = rd_en ? rd_ptr_q[ADDR_WIDTH-1:0] : '0;
        lat_sr_d        = (lat_sr_q << 1) | RD_LAT'(rd_en);
        infl_d          = infl_q + CW'(rd_en) - CW'(lat_sr_q[RD_LAT-1]);
        if (pop)
            beat_d = beat_q + NWW'(1);
        unique case (state_q)
            S_IDLE:  if (rdy_for_fwd) state_d = S_CLAIM;
            S_CLAIM: begin
                rdy_for_fwd_ack = 1'b1;
                state_d         = S_LEN;
            end
            S_LEN: begin
                len_d    = len_calc;
                nw_d     = nw_calc;
                rd_ptr_d = '0;
                beat_d   = '0;
                state_d  = (fwd_byte_len == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
                if (rd_en) begin
                    rd_ptr_d = rd_ptr_q + NWW'(1);
                    if (rd_ptr_q == nw_q - NWW'(1))
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (pop && is_last) state_d = S_DONE;
            S_DONE: begin
                fwd_done = 1'b1;
                if (fwd_done_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            nw_q     <= '0;
            rd_ptr_q <= '0;
            beat_q   <= '0;
            lat_sr_q <= '0;
            infl_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            nw_q     <= nw_d;
            rd_ptr_q <= rd_ptr_d;
            beat_q   <= beat_d;
            lat_sr_q <= lat_sr_d;
            infl_q   <= infl_d;
        end
    end

    // Skid FIFO holding returned words until the stream accepts them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rdp_q <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= fwd_rd_data;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop)
                rdp_q <= rdp_q + PW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

`ifdef FWD_AXIS_STATS_EN
    // Packet and byte totals, bumped at the done handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_pkt_cnt  <= '0;
            fwd_byte_cnt <= '0;
        end else if (state_q == S_DONE && fwd_done_ack) begin
            fwd_pkt_cnt  <= fwd_pkt_cnt + 32'd1;
            fwd_byte_cnt <= fwd_byte_cnt + 64'(len_q);
        end
    end
`endif

endmodule

// File: tb/tb_fwd_axis_reader.sv
// Scoreboard bench for fwd_axis_reader: buffer read model with RD_LAT latency,
// directed packets with hand-computed beat counts and last-beat keep masks.
`timescale 1ns/1ps
module tb_fwd_axis_reader;
    localparam int AW = 9, DW = 64, PLW = 32, RDL = 3, FD = 4;

    logic            clk = 1'b0, rst = 1'b0;
    logic            rdy_for_fwd = 1'b0, rdy_for_fwd_ack;
    logic [AW-1:0]   fwd_addr;
    logic            fwd_rd_en;
    logic [DW-1:0]   fwd_rd_data = '0;
    logic            fwd_rd_data_vld = 1'b0;
    logic [PLW-1:0]  fwd_byte_len = '0;
    logic            fwd_done, fwd_done_ack = 1'b0;
    logic [DW-1:0]   m_axis_tdata;
    logic [DW/8-1:0] m_axis_tkeep;
    logic            m_axis_tlast, m_axis_tvalid, m_axis_tready;
`ifdef FWD_AXIS_STATS_EN
    logic [31:0]     fwd_pkt_cnt;
    logic [63:0]     fwd_byte_cnt;
`endif

    fwd_axis_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PLEN_WIDTH(PLW), .RD_LAT(RDL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst),
        .rdy_for_fwd(rdy_for_fwd), .rdy_for_fwd_ack(rdy_for_fwd_ack),
        .fwd_addr(fwd_addr), .fwd_rd_en(fwd_rd_en),
        .fwd_rd_data(fwd_rd_data), .fwd_rd_data_vld(fwd_rd_data_vld),
        .fwd_byte_len(fwd_byte_len),
        .fwd_done(fwd_done), .fwd_done_ack(fwd_done_ack),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
`ifdef FWD_AXIS_STATS_EN
        , .fwd_pkt_cnt(fwd_pkt_cnt), .fwd_byte_cnt(fwd_byte_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] d; logic [7:0] k; logic l; } beat_t;
    typedef struct { int due; logic [AW-1:0] a; } rd_t;

    beat_t      exp_q[$];
    rd_t        rq[$];
    int         cyc = 0, passed = 0, total = 0;
    int         beats_seen = 0, ack_cnt = 0, rd_cnt = 0, tr_mode = 0;
    logic [7:0] cur_id = 8'h00;

    function automatic logic [63:0] word_of(input logic [7:0] id, input int unsigned a);
        return {id, 24'hC0FFEE, a};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Buffer read port model: word returned RDL cycles after the strobe.
    initial begin
        forever begin
            @(posedge clk); cyc++; #1;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                fwd_rd_data_vld = 1'b1;
                fwd_rd_data     = word_of(cur_id, rq[0].a);
                rq.delete(0);
            end else begin
                fwd_rd_data_vld = 1'b0;
                fwd_rd_data     = '0;
            end
            @(negedge clk);
            if (rst && fwd_rd_en) begin
                rq.push_back('{cyc + RDL, fwd_addr});
                rd_cnt++;
            end
        end
    end

    // Downstream ready: constant 1, or repeating 1-0-0-1.
    initial begin
        int p = 0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (tr_mode == 1) begin
                m_axis_tready = (p % 4 == 0) || (p % 4 == 3);
                p++;
            end else m_axis_tready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each accepted beat, checks stall stability.
    initial begin
        beat_t h;
        bit    have_h = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin have_h = 0; continue; end
            if (rdy_for_fwd_ack) ack_cnt++;
            if (have_h)
                check("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast},
                      {1'b1, h.d, h.k, h.l});
            have_h = 0;
            if (m_axis_tvalid) begin
                if (m_axis_tready) begin
                    beat_t e;
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL extra_beat: got data %0h expected no beat", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("beat%0d", beats_seen),
                              {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, {e.d, e.k, e.l});
                    end
                    beats_seen++;
                end else begin
                    h.d = m_axis_tdata; h.k = m_axis_tkeep; h.l = m_axis_tlast;
                    have_h = 1;
                end
            end
        end
    end

    task automatic check_outputs_zero(input string name);
        check(name, {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                     fwd_rd_en, fwd_addr, fwd_done, rdy_for_fwd_ack}, '0);
    endtask

    // One packet: len, id, ready mode, change len after LEN, reset at beat (-1 none),
    // expected beat count, expected last-beat keep.
    task automatic run_pkt(input int unsigned len, input logic [7:0] id, input int mode,
                           input bit change_len, input int rst_at,
                           input int exp_nw, input logic [7:0] last_keep);
        int ack0, rd0, b0, claim_cyc;
        bit got;
        for (int i = 0; i < exp_nw; i++)
            exp_q.push_back('{word_of(id, i), (i == exp_nw - 1) ? last_keep : 8'hFF,
                              (i == exp_nw - 1)});
        cur_id = id; tr_mode = mode;
        ack0 = ack_cnt; rd0 = rd_cnt; b0 = beats_seen; claim_cyc = 0;
        @(posedge clk); #1;
        fwd_byte_len = len; rdy_for_fwd = 1'b1;
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #1;
            if (rdy_for_fwd_ack) begin got = 1; claim_cyc = cyc; break; end
        end
        check($sformatf("claim_seen_L%0d", len), got, 1);
        @(posedge clk); #1; rdy_for_fwd = 1'b0;
        @(posedge clk); #1; if (change_len) fwd_byte_len = 32'd64;
        if (rst_at >= 0) begin
            for (int n = 0; n < 5000; n++) begin
                @(negedge clk); #1;
                if (beats_seen - b0 >= rst_at) break;
            end
            check("beats_before_reset", 32'(beats_seen - b0), 32'(rst_at));
            @(posedge clk); #2; rst = 1'b0; #1;
            check_outputs_zero("outputs_in_reset");
            exp_q.delete(); rq.delete();
            repeat (3) @(posedge clk);
            #1; rst = 1'b1;
            got = 0;
            for (int n = 0; n < 30; n++) begin
                @(negedge clk);
                if (fwd_done || m_axis_tvalid || fwd_rd_en) got = 1;
            end
            check("idle_after_reset_no_done", got, 0);
            return;
        end
        got = 0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk); #1;
            if (fwd_done) begin got = 1; break; end
        end
        check($sformatf("done_seen_L%0d", len), got, 1);
        if (len == 0) check("done_cycle_L0", 32'(cyc), 32'(claim_cyc + 2));
        check($sformatf("all_beats_L%0d", len), 32'(exp_q.size()), 32'd0);
        check($sformatf("beat_count_L%0d", len), 32'(beats_seen - b0), 32'(exp_nw));
        check($sformatf("read_count_L%0d", len), 32'(rd_cnt - rd0), 32'(exp_nw));
        check($sformatf("ack_pulses_L%0d", len), 32'(ack_cnt - ack0), 32'd1);
        if (len != 0) begin
            repeat (2) @(negedge clk);
            check($sformatf("done_held_L%0d", len), fwd_done, 1);
        end
        fwd_done_ack = 1'b1;
        @(posedge clk); #1;
        fwd_done_ack = 1'b0;
        check($sformatf("done_released_L%0d", len), fwd_done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs");
        rst = 1'b1;
        run_pkt(16,   8'h01, 0, 0, -1,   2, 8'hFF);
        run_pkt(13,   8'h02, 0, 1, -1,   2, 8'hF8);
`ifdef FWD_AXIS_STATS_EN
        check("pkt_cnt_2", fwd_pkt_cnt, 32'd2);
        check("byte_cnt_2", fwd_byte_cnt, 64'd29);
`endif
        run_pkt(0,    8'h03, 0, 0, -1,   0, 8'hFF);
        run_pkt(80,   8'h04, 1, 0, -1,  10, 8'hFF);
        run_pkt(8192, 8'h05, 0, 0, -1, 512, 8'hFF);
`ifdef FWD_AXIS_STATS_EN
        check("pkt_cnt_5", fwd_pkt_cnt, 32'd5);
        check("byte_cnt_5", fwd_byte_cnt, 64'd4205);
`endif
        run_pkt(8192, 8'h06, 0, 0, 200, 512, 8'hFF);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fwd_axis_reader.md
Name: fwd_axis_reader

Overview:
- Forwarder-side agent for the P3 packet buffer system; the reader at the far end of the forwarder interface.
- Claims a filled, accepted buffer through the rdy/ack handshake, reads the packet out word by word, and emits it as an AXI-Stream master with TKEEP/TLAST and full backpressure support.
- Reports completion with the done/done_ack handshake so the buffer returns to the snooper.

Parameters:
- ADDR_WIDTH, 9, word address width of forwarder port (buffer depth 2^ADDR_WIDTH words)
- DATA_WIDTH, 64, word width in bits; multiple of 8; BYTES = DATA_WIDTH/8
- PLEN_WIDTH, 32, packet byte-length width
- RD_LAT, 1, cycles from fwd_rd_en to fwd_rd_data_vld (1 + BUF_IN + BUF_OUT + PESS of buffers); 1..4
- FIFO_DEPTH, 4, output skid FIFO entries; must be >= RD_LAT+1; power of 2

Ports:
- clk  in  1  sole clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- rdy_for_fwd  in  1  P3 has a buffer ready for forwarding
- rdy_for_fwd_ack  out  1  one-cycle claim pulse
- fwd_addr  out  ADDR_WIDTH  word read address
- fwd_rd_en  out  1  read strobe
- fwd_rd_data  in  DATA_WIDTH  read word
- fwd_rd_data_vld  in  1  read word valid, RD_LAT after strobe
- fwd_byte_len  in  PLEN_WIDTH  packet length in bytes of claimed buffer
- fwd_done  out  1  packet fully sent; held until acked
- fwd_done_ack  in  1  P3 released buffer
- m_axis_tdata  out  DATA_WIDTH  stream data, word passed unchanged
- m_axis_tkeep  out  BYTES  valid-byte mask
- m_axis_tlast  out  1  last beat of packet
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream accept

Behaviour:
- Reset (rst low, async): FSM=IDLE, FIFO/counters cleared; all outputs 0. Mid-packet reset abandons packet; no done issued.
- FSM states IDLE, CLAIM, LEN, READ, DRAIN, DONE.
- IDLE: rdy_for_fwd=1 -> CLAIM. CLAIM: rdy_for_fwd_ack=1 exactly one cycle -> LEN.
- LEN (one cycle; mux has switched): latch L=fwd_byte_len; NW=ceil(L/BYTES), clamped to 2^ADDR_WIDTH; L clamped to NW*BYTES. L=0 -> DONE directly, no beats. Else -> READ with rd_ptr=0.
- READ: fwd_rd_en=1, fwd_addr=rd_ptr when rd_ptr<NW and fifo_count+inflight<FIFO_DEPTH; rd_ptr++ per strobe. inflight tracked by RD_LAT shift register. After NW strobes -> DRAIN.
- Every fwd_rd_data_vld pushes fwd_rd_data into FIFO; never overflows by credit rule; vld outside READ/DRAIN ignored.
- Output: tvalid = FIFO non-empty; pop on tvalid&&tready. Beat counter beat_idx; tlast=1 when beat_idx==NW-1. tkeep all-ones except last beat: r=L mod BYTES, r!=0 -> upper r bits of tkeep set (byte 0 in MSB lane), lower BYTES-r cleared. tdata/tkeep/tlast stable while tvalid&&!tready.
- Throughput: one beat/cycle sustained when tready=1 and FIFO_DEPTH>=RD_LAT+1.
- DRAIN: last beat accepted -> DONE.
- DONE: fwd_done=1 until fwd_done_ack sampled high (ack in first DONE cycle accepted); then fwd_done=0, -> IDLE. Next claim no earlier than cycle after ack.
- rdy_for_fwd deasserted outside IDLE: ignored.

Optional Feature:
- Macro FWD_AXIS_STATS_EN.
- Defined: extra outputs fwd_pkt_cnt (32 b) and fwd_byte_cnt (64 b), reset 0; on done handshake add 1 and L respectively; wrap modulo width.
- Undefined: ports absent, no counters; all other behaviour identical.

Test Plan:
- L=16, DATA_WIDTH=64, tready=1: one ack pulse; reads addr 0,1; 2 beats, tkeep 0xFF both, tlast on beat 1; done then ack -> IDLE.
- L=13: 2 beats; beat 1 tkeep=0xF8 (r=5), tlast=1; fwd_byte_len changed after LEN has no effect.
- L=0: no fwd_rd_en, no tvalid; fwd_done one cycle after LEN; ack same cycle accepted.
- L=80 (10 words), RD_LAT=3, FIFO_DEPTH=4, tready toggling 1-0-0-1: no FIFO overflow, all 10 words in order, data held stable while stalled.
- L=8192 (> 512 words x 8 B = 4096 B): exactly 512 beats, last tkeep=0xFF; reset asserted at beat 200: outputs 0 immediately, IDLE, no fwd_done.
- FWD_AXIS_STATS_EN defined, packets L=13 then L=16: fwd_pkt_cnt=2, fwd_byte_cnt=29.
